// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage load/store engine and memory.
// Single-cycle ack handshake; the master holds req and the request fields until ack.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: big-endian lane steering, req/ack bus transaction
// with timeout, load extension, and writeback forwarding with pipeline stall.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          aluop_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         reg2_i,
    input  logic [4:0]          wreg_addr_i,
    input  logic                wreg_enable_i,
    input  logic [31:0]         wdata_i,
    output logic [4:0]          wreg_addr_o,
    output logic                wreg_enable_o,
    output logic [31:0]         wdata_o,
    output logic                stallreq,
    output logic                misalign_o,
    output logic                buserr_o,
    mem_access_unit_if.master   dbus
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    // Counter value seen in the last ACCESS cycle before the timeout aborts.
    localparam logic [CNT_W-1:0] LAST_CNT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e      state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [31:0] result;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic        we_q, load_q, signed_q, buserr_q;
    logic [1:0]  off_q;
    size_e       size_q;

    // Decode of the incoming op.
    logic        is_mem, is_load, is_signed, misaligned;
    size_e       size;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;

    always_comb begin
        is_mem    = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        unique case (aluop_i)
            OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_B; end
            OP_LBU:  begin is_load = 1'b1; size = SZ_B; end
            OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_H; end
            OP_LHU:  begin is_load = 1'b1; size = SZ_H; end
            OP_LW:   is_load = 1'b1;
            OP_SB:   size = SZ_B;
            OP_SH:   size = SZ_H;
            OP_SW:   size = SZ_W;
            default: is_mem = 1'b0;
        endcase
        misaligned = is_mem && (((size == SZ_H) && mem_addr_i[0]) ||
                                ((size == SZ_W) && (mem_addr_i[1:0] != 2'b00)));
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = reg2_i;
        case (size)
            SZ_B: begin
                sel_d   = 4'b1000 >> mem_addr_i[1:0];
                wdata_d = {4{reg2_i[7:0]}};
            end
            SZ_H: begin
                sel_d   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{reg2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction of the returned word, using the fields latched at issue.
    logic [31:0] load_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = dbus.rdata[31:24];
            2'd1:    rd_byte = dbus.rdata[23:16];
            2'd2:    rd_byte = dbus.rdata[15:8];
            default: rd_byte = dbus.rdata[7:0];
        endcase
        rd_half = off_q[1] ? dbus.rdata[15:0] : dbus.rdata[31:16];
        case (size_q)
            SZ_B:    load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SZ_H:    load_data = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_data = dbus.rdata;
        endcase
    end

    // FSM next state and outputs.
    logic start, capture, abort, timeout_hit;
    logic wen_c, stall_c, misalign_c;
    logic [31:0] wdata_c;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == LAST_CNT);

    always_comb begin
        state_d    = state;
        start      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        wen_c      = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        wdata_c    = wdata_i;
        case (state)
            IDLE: begin
                if (!is_mem) begin
                    wen_c = wreg_enable_i;
                end else if (misaligned) begin
                    misalign_c = 1'b1;
                end else begin
                    start   = 1'b1;
                    stall_c = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (dbus.ack) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (load_q) begin
                    wdata_c = result;
                    wen_c   = wreg_enable_i && !buserr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the pass-through outputs are combinational from the inputs, so they
    // are forced low by rst directly; a state-only reset would leave them live.
    assign wreg_addr_o   = rst ? 5'd0  : wreg_addr_i;
    assign wreg_enable_o = !rst && wen_c;
    assign wdata_o       = rst ? 32'd0 : wdata_c;
    assign stallreq      = !rst && stall_c;
    assign misalign_o    = !rst && misalign_c;
    assign buserr_o      = buserr_q;

    assign dbus.req   = (state == ACCESS);
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.sel   = sel_q;
    assign dbus.wdata = wdata_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            result   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            load_q   <= 1'b0;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            size_q   <= SZ_W;
            buserr_q <= 1'b0;
        end else begin
            state    <= state_d;
            buserr_q <= abort;
            if (start) begin
                addr_q   <= {mem_addr_i[31:2], 2'b00};
                sel_q    <= sel_d;
                we_q     <= !is_load;
                wdata_q  <= wdata_d;
                load_q   <= is_load;
                signed_q <= is_signed;
                off_q    <= mem_addr_i[1:0];
                size_q   <= size;
                cnt      <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            if (capture && load_q) begin
                result <= load_data;
            end
        end
    end
endmodule
